// File: rtl/stream_matrix_pkg.sv
// Shared write-FSM state type and bank/address helpers for the stream matrix bank.
package stream_matrix_pkg;

  typedef enum logic [1:0] {
    WRRESET = 2'd0,
    WRIDLE  = 2'd1,
    WRDATA  = 2'd2
  } wstate_t;

  localparam int NUM_BANKS = 2;
  localparam int BANK_W    = 1;

  function automatic int index_w(input int mem_depth);
    return $clog2(mem_depth);
  endfunction

  // Full memory address: bank index on top of the element index.
  function automatic int mem_addr_w(input int mem_depth);
    return BANK_W + $clog2(mem_depth);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// AXI-stream bundle; axi_in is the sink view used by stream_matrix_bank.
interface axi_stream_if #(
  parameter int D_W = 8
);
  logic [D_W-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  modport axi_in  (input tdata, input tvalid, input tlast, output tready);
  modport axi_out (output tdata, output tvalid, output tlast, input tready);
endinterface

// File: rtl/stream_matrix_bank_mem_top.sv
// mem_top: simple dual-port RAM, port A writes, port B reads with a registered output.
module mem_top #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8192,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_din,
  input  logic             b_en,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
  end

  // Read register resets to zero and holds while b_en is low.
  always_ff @(posedge clk) begin
    if (rst)       b_dout <= '0;
    else if (b_en) b_dout <= mem[b_addr];
  end

endmodule

// File: rtl/stream_matrix_bank.sv
// Double-buffered stream sink: fills two banks from an AXI stream, serves them by random access.
// Optional tlast checking is built when STREAM_MATRIX_BANK_TLAST_CHECK_EN is defined.
module stream_matrix_bank
  import stream_matrix_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int MATRIXSIZE_W = 24,
  parameter int MEM_DEPTH    = 4096,
  parameter int ADDR_W       = index_w(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_stream_if.axi_in            in_mat,
  input  logic [MATRIXSIZE_W-1:0] DEPTH,
  output logic                    bank_valid,
  input  logic                    bank_release,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [D_W-1:0]          rd_data,
  output logic                    rd_bank,
  output logic                    err_tlast
);

  localparam int              MEM_AW    = mem_addr_w(MEM_DEPTH);
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(MEM_DEPTH);

  wstate_t           state, state_nxt;
  logic              ready;
  logic [1:0]        full;
  logic              w_sel, r_sel;
  logic [ADDR_W-1:0] wcnt;
  logic [CNT_W-1:0]  dlat;
  logic              hs, last_beat, release_ok, depth_ok, latch_depth;

  assign hs          = in_mat.tvalid && ready;
  assign last_beat   = ({1'b0, wcnt} == (dlat - CNT_W'(1)));
  assign release_ok  = bank_release && full[r_sel];
  assign depth_ok    = (DEPTH != '0) && (DEPTH <= MATRIXSIZE_W'(MEM_DEPTH));
  assign latch_depth = (state == WRIDLE) && !full[w_sel];

  assign in_mat.tready = ready;
  assign bank_valid    = full[r_sel];
  assign rd_bank       = r_sel;

  always_ff @(posedge clk) begin
    if (rst) state <= WRRESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    unique case (state)
      WRRESET: state_nxt = WRIDLE;
      WRIDLE:  if (!full[w_sel]) state_nxt = WRDATA;
      WRDATA: begin
        ready = 1'b1;
        if (hs && last_beat) state_nxt = WRIDLE;
      end
      default: state_nxt = WRRESET;
    endcase
  end

  // Release and completion never hit the same bank: the writer only fills an empty bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= '0;
      w_sel <= 1'b0;
      r_sel <= 1'b0;
      wcnt  <= '0;
      dlat  <= DEPTH_MAX;
    end else begin
      if (latch_depth) dlat <= depth_ok ? DEPTH[CNT_W-1:0] : DEPTH_MAX;
      if (release_ok) begin
        full[r_sel] <= 1'b0;
        r_sel       <= ~r_sel;
      end
      if (hs) begin
        if (last_beat) begin
          full[w_sel] <= 1'b1;
          w_sel       <= ~w_sel;
          wcnt        <= '0;
        end else begin
          wcnt <= wcnt + ADDR_W'(1);
        end
      end
    end
  end

  mem_top #(
    .WIDTH (D_W),
    .DEPTH (NUM_BANKS * MEM_DEPTH),
    .AW    (MEM_AW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .a_we   (hs),
    .a_addr ({w_sel, wcnt}),
    .a_din  (in_mat.tdata),
    .b_en   (rd_en),
    .b_addr ({r_sel, rd_addr}),
    .b_dout (rd_data)
  );

`ifdef STREAM_MATRIX_BANK_TLAST_CHECK_EN
  logic err_q;

  // Sticky: tlast must coincide exactly with the count-defined final element.
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (hs && (in_mat.tlast != last_beat)) err_q <= 1'b1;
  end

  assign err_tlast = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = in_mat.tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_stream_matrix_bank.sv
// Bench for stream_matrix_bank: directed sequences, a DEPTH table, and a randomized ledger model.
module tb_stream_matrix_bank;

  localparam int D_W          = 8;
  localparam int MATRIXSIZE_W = 24;
  localparam int MEM_DEPTH    = 16;
  localparam int ADDR_W       = 4;

`ifdef STREAM_MATRIX_BANK_TLAST_CHECK_EN
  localparam logic TL_ON = 1'b1;
`else
  localparam logic TL_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_stream_if #(.D_W(D_W)) in_mat ();

  logic [MATRIXSIZE_W-1:0] depth;
  logic                    bank_valid;
  logic                    bank_release;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [D_W-1:0]          rd_data;
  logic                    rd_bank;
  logic                    err_tlast;

  stream_matrix_bank #(
    .D_W          (D_W),
    .MATRIXSIZE_W (MATRIXSIZE_W),
    .MEM_DEPTH    (MEM_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_mat       (in_mat),
    .DEPTH        (depth),
    .bank_valid   (bank_valid),
    .bank_release (bank_release),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_bank      (rd_bank),
    .err_tlast    (err_tlast)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    in_mat.tvalid = 1'b0;
    in_mat.tlast  = 1'b0;
    in_mat.tdata  = '0;
    bank_release  = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    tick();
    tick();
    check("rst_tready", in_mat.tready, 0);
    check("rst_bank_valid", bank_valid, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_tlast", err_tlast, 0);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int waited = 0;
    while (in_mat.tready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (in_mat.tready !== 1'b1) check(name, in_mat.tready, 1);
  endtask

  task automatic send_elem(input logic [D_W-1:0] d, input logic l);
    in_mat.tvalid = 1'b1;
    in_mat.tdata  = d;
    in_mat.tlast  = l;
    wait_ready("send_tready_timeout");
    tick();
    in_mat.tvalid = 1'b0;
    in_mat.tlast  = 1'b0;
  endtask

  task automatic send_mat(input logic [D_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) send_elem(D_W'(base + D_W'(i)), 1'b0);
  endtask

  task automatic read_chk(input int addr, input logic [D_W-1:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(addr);
    tick();
    rd_en = 1'b0;
    check(name, rd_data, exp);
  endtask

  // ---------------- DEPTH table ----------------
  typedef struct {
    int depth_in;
    int exp_len;
  } depth_vec_t;

  depth_vec_t vecs [6];

  // ---------------- randomized ledger model ----------------
  logic [D_W-1:0] m_mem [2*MEM_DEPTH];
  logic           m_full [2];
  logic           m_w, m_r;
  int             m_wcnt, m_dlat;
  logic [D_W-1:0] exp_q [$];
  logic [D_W-1:0] last_rd;
  logic           r_hs, r_rel;
  logic [D_W-1:0] r_data;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 1};
    vecs[1] = '{4, 4};
    vecs[2] = '{16, 16};
    vecs[3] = '{0, 16};
    vecs[4] = '{17, 16};
    vecs[5] = '{1000, 16};

    // Basic: reset-to-tready timing and one 4-element matrix.
    depth = 4;
    do_reset();
    tick();
    check("tready_after_1", in_mat.tready, 0);
    tick();
    check("tready_after_2", in_mat.tready, 1);
    send_mat(8'd1, 3);
    check("basic_valid_before_last", bank_valid, 0);
    send_elem(8'd4, 1'b0);
    check("basic_valid_after_last", bank_valid, 1);
    check("basic_rd_bank", rd_bank, 0);
    for (int i = 0; i < 4; i++) read_chk(i, D_W'(i + 1), "basic_read");
    tick();
    check("basic_rd_hold", rd_data, 4);

    // Three matrices without release: the third waits for bank 0.
    do_reset();
    send_mat(8'h10, 4);
    send_mat(8'h20, 4);
    check("three_bank1_valid", bank_valid, 1);
    in_mat.tvalid = 1'b1;
    in_mat.tdata  = 8'h30;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("three_blocked_tready", in_mat.tready, 0);
    end
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("three_rd_bank_after_rel", rd_bank, 1);
    check("three_tready_rel_plus1", in_mat.tready, 0);
    tick();
    check("three_tready_rel_plus2", in_mat.tready, 1);
    send_mat(8'h30, 4);
    check("three_valid_bank1", bank_valid, 1);
    read_chk(0, 8'h20, "three_bank1_a0");
    read_chk(3, 8'h23, "three_bank1_a3");
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("three_rd_bank_back0", rd_bank, 0);
    check("three_valid_bank0", bank_valid, 1);
    read_chk(0, 8'h30, "three_bank0_a0");
    read_chk(3, 8'h33, "three_bank0_a3");

    // Release with no valid bank is ignored.
    do_reset();
    tick();
    tick();
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("idle_rel_valid", bank_valid, 0);
    check("idle_rel_rd_bank", rd_bank, 0);
    check("idle_rel_tready", in_mat.tready, 1);
    send_mat(8'h60, 4);
    check("idle_rel_bank0", rd_bank, 0);
    check("idle_rel_fill_valid", bank_valid, 1);
    read_chk(2, 8'h62, "idle_rel_read");
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("idle_rel_real_release_valid", bank_valid, 0);
    check("idle_rel_real_release_bank", rd_bank, 1);

    // Release of bank 0 in the same cycle bank 1 completes.
    do_reset();
    send_mat(8'h40, 4);
    send_mat(8'h50, 3);
    in_mat.tvalid = 1'b1;
    in_mat.tdata  = 8'h53;
    wait_ready("simul_tready_timeout");
    bank_release = 1'b1;
    tick();
    bank_release  = 1'b0;
    in_mat.tvalid = 1'b0;
    check("simul_rd_bank", rd_bank, 1);
    check("simul_valid", bank_valid, 1);
    check("simul_tready_idle", in_mat.tready, 0);
    tick();
    check("simul_tready_resume", in_mat.tready, 1);
    read_chk(0, 8'h50, "simul_read_a0");
    read_chk(3, 8'h53, "simul_read_a3");

    // tlast on element 2 of 4.
    do_reset();
    send_elem(8'hA0, 1'b0);
    check("tlast_err_clean", err_tlast, 0);
    send_elem(8'hA1, 1'b1);
    check("tlast_err_set", err_tlast, TL_ON);
    send_elem(8'hA2, 1'b0);
    check("tlast_not_early", bank_valid, 0);
    send_elem(8'hA3, 1'b0);
    check("tlast_completes", bank_valid, 1);
    check("tlast_err_sticky", err_tlast, TL_ON);

    // Reset after 2 of 4 elements discards the partial matrix.
    do_reset();
    send_mat(8'h90, 4);
    read_chk(0, 8'h90, "midrst_pre_read");
    send_mat(8'h55, 2);
    do_reset();
    send_mat(8'h71, 2);
    check("midrst_partial_not_valid", bank_valid, 0);
    send_mat(8'h73, 2);
    check("midrst_valid", bank_valid, 1);
    check("midrst_rd_bank", rd_bank, 0);
    read_chk(0, 8'h71, "midrst_read_a0");
    read_chk(3, 8'h74, "midrst_read_a3");

    // DEPTH table, including illegal values that fall back to MEM_DEPTH.
    foreach (vecs[k]) begin
      depth = MATRIXSIZE_W'(vecs[k].depth_in);
      do_reset();
      for (int i = 0; i < vecs[k].exp_len - 1; i++) send_elem(D_W'(i * 7 + k * 16 + 3), 1'b0);
      check("tbl_valid_before_last", bank_valid, 0);
      send_elem(D_W'((vecs[k].exp_len - 1) * 7 + k * 16 + 3), 1'b0);
      check("tbl_valid_after_last", bank_valid, 1);
      read_chk(0, D_W'(k * 16 + 3), "tbl_read_first");
      read_chk(vecs[k].exp_len - 1, D_W'((vecs[k].exp_len - 1) * 7 + k * 16 + 3), "tbl_read_last");
    end

    // Randomized traffic against the bank ledger.
    depth = MATRIXSIZE_W'($urandom_range(1, MEM_DEPTH));
    do_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_w       = 1'b0;
    m_r       = 1'b0;
    m_wcnt    = 0;
    m_dlat    = int'(depth);
    last_rd   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_mat.tvalid = ($urandom_range(0, 9) < 7);
      in_mat.tdata  = D_W'($urandom);
      in_mat.tlast  = (m_wcnt == m_dlat - 1);
      bank_release  = ($urandom_range(0, 11) == 0);
      rd_en         = 1'b0;
      if (m_full[m_r] && ($urandom_range(0, 1) == 1)) begin
        rd_en   = 1'b1;
        rd_addr = ADDR_W'($urandom_range(0, m_dlat - 1));
        exp_q.push_back(m_mem[{m_r, rd_addr}]);
      end
      if (m_full[m_w]) check("rnd_tready_blocked", in_mat.tready, 0);
      r_hs   = in_mat.tvalid && in_mat.tready;
      r_rel  = bank_release && m_full[m_r];
      r_data = in_mat.tdata;
      tick();
      if (r_rel) begin
        m_full[m_r] = 1'b0;
        m_r         = ~m_r;
      end
      if (r_hs) begin
        m_mem[{m_w, ADDR_W'(m_wcnt)}] = r_data;
        if (m_wcnt == m_dlat - 1) begin
          m_full[m_w] = 1'b1;
          m_w         = ~m_w;
          m_wcnt      = 0;
        end else begin
          m_wcnt++;
        end
      end
      check("rnd_bank_valid", bank_valid, m_full[m_r]);
      check("rnd_rd_bank", rd_bank, m_r);
      if (rd_en && exp_q.size() > 0) last_rd = exp_q.pop_front();
      check("rnd_rd_data", rd_data, last_rd);
    end
    in_mat.tvalid = 1'b0;
    bank_release  = 1'b0;
    rd_en         = 1'b0;
    tick();
    check("rnd_err_tlast_clean", err_tlast, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
